// File: rtl/instr_reg_pkg.sv
// Shared field layout, opcode class boundaries and class encoding for the
// 16-bit instruction register and its decoder.
package instr_reg_pkg;

  localparam int WORD_W  = 16;
  localparam int FIELD_W = 4;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int IMM_W   = 8;

  // Last opcode of each class; SYS takes everything above BRANCH_MAX.
  localparam logic [FIELD_W-1:0] ALU_MAX    = 4'd7;
  localparam logic [FIELD_W-1:0] MEM_MAX    = 4'd11;
  localparam logic [FIELD_W-1:0] BRANCH_MAX = 4'd13;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_MEM    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_SYS    = 2'd3
  } ir_cls_t;

  function automatic ir_cls_t classify(input logic [FIELD_W-1:0] opc);
    if (opc <= ALU_MAX)         return CLS_ALU;
    else if (opc <= MEM_MAX)    return CLS_MEM;
    else if (opc <= BRANCH_MAX) return CLS_BRANCH;
    else                        return CLS_SYS;
  endfunction

endpackage

// File: rtl/instr_reg_decode.sv
// Purely combinational field split, immediate sign-extension and class
// lookup for a registered 16-bit instruction word.
module instr_reg_decode
  import instr_reg_pkg::*;
(
  input  logic [WORD_W-1:0]  word_i,
  output logic [FIELD_W-1:0] opcode_o,
  output logic [FIELD_W-1:0] rd_o,
  output logic [FIELD_W-1:0] rs_o,
  output logic [FIELD_W-1:0] func_o,
  output logic [WORD_W-1:0]  imm_sext_o,
  output ir_cls_t            cls_o
);

  assign opcode_o   = word_i[OPC_MSB:OPC_LSB];
  assign rd_o       = word_i[RD_LSB+FIELD_W-1:RD_LSB];
  assign rs_o       = word_i[RS_LSB+FIELD_W-1:RS_LSB];
  assign func_o     = word_i[FIELD_W-1:0];
  assign imm_sext_o = {{(WORD_W-IMM_W){word_i[IMM_W-1]}}, word_i[IMM_W-1:0]};
  assign cls_o      = classify(word_i[OPC_MSB:OPC_LSB]);

endmodule

// File: rtl/instr_reg.sv
// Instruction register: captures the fetched word on en_ir, flags validity
// and exposes pre-decoded fields. Define IR_SHADOW_EN to add prev_ir.
module instr_reg
  import instr_reg_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  input  logic         en_ir,
  output logic [W-1:0] d_out,
  output logic         ir_valid,
  output logic [3:0]   opcode,
  output logic [3:0]   rd,
  output logic [3:0]   rs,
  output logic [3:0]   func,
  output logic [15:0]  imm_sext,
`ifdef IR_SHADOW_EN
  output logic [15:0]  prev_ir,
`endif
  output logic [1:0]   cls
);

  logic [W-1:0] ir_d, ir_q;
  logic         valid_d, valid_q;
  ir_cls_t      cls_w;

  always_comb begin
    // NOTE: hold values are assigned first so every path drives every
    // signal; an unassigned branch here would infer a latch.
    ir_d    = ir_q;
    valid_d = valid_q;
    if (en_ir) begin
      ir_d    = d_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

`ifdef IR_SHADOW_EN
  logic [W-1:0] prev_d, prev_q;

  // The shadow only moves when the main register loads.
  assign prev_d = en_ir ? ir_q : prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  assign prev_ir = prev_q;
`endif

  assign d_out    = ir_q;
  assign ir_valid = valid_q;
  assign cls      = cls_w;

  instr_reg_decode u_decode (
    .word_i     (ir_q),
    .opcode_o   (opcode),
    .rd_o       (rd),
    .rs_o       (rs),
    .func_o     (func),
    .imm_sext_o (imm_sext),
    .cls_o      (cls_w)
  );

endmodule

// File: tb/tb_instr_reg.sv
// Self-checking bench for instr_reg: directed test-plan steps followed by
// randomized traffic, compared against an arithmetic reference model.
module tb_instr_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        en_ir;
  logic [15:0] d_out;
  logic        ir_valid;
  logic [3:0]  opcode, rd, rs, func;
  logic [15:0] imm_sext;
  logic [1:0]  cls;
`ifdef IR_SHADOW_EN
  logic [15:0] prev_ir;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last loaded word, valid flag, previous word.
  int m_word  = 0;
  int m_valid = 0;
  int m_prev  = 0;

  instr_reg #(.W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .en_ir    (en_ir),
    .d_out    (d_out),
    .ir_valid (ir_valid),
    .opcode   (opcode),
    .rd       (rd),
    .rs       (rs),
    .func     (func),
    .imm_sext (imm_sext),
`ifdef IR_SHADOW_EN
    .prev_ir  (prev_ir),
`endif
    .cls      (cls)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int op, b, exp_imm, exp_cls;
    op = (m_word / 4096) % 16;
    b  = m_word % 256;
    exp_imm = (b >= 128) ? (b + 65280) : b;
    if (op < 8)       exp_cls = 0;
    else if (op < 12) exp_cls = 1;
    else if (op < 14) exp_cls = 2;
    else              exp_cls = 3;
    check({tag, ".d_out"},    d_out,              16'(m_word));
    check({tag, ".valid"},    {15'b0, ir_valid},  16'(m_valid));
    check({tag, ".opcode"},   {12'b0, opcode},    16'(op));
    check({tag, ".rd"},       {12'b0, rd},        16'((m_word / 256) % 16));
    check({tag, ".rs"},       {12'b0, rs},        16'((m_word / 16) % 16));
    check({tag, ".func"},     {12'b0, func},      16'(m_word % 16));
    check({tag, ".imm_sext"}, imm_sext,           16'(exp_imm));
    check({tag, ".cls"},      {14'b0, cls},       16'(exp_cls));
`ifdef IR_SHADOW_EN
    check({tag, ".prev_ir"},  prev_ir,            16'(m_prev));
`endif
  endtask

  // Drive after the falling edge, apply one rising edge, update the model,
  // then sample on the next falling edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [15:0] din);
    rst   = r;
    en_ir = e;
    d_in  = din;
    @(posedge clk);
    if (r) begin
      m_word = 0; m_valid = 0; m_prev = 0;
    end else if (e) begin
      m_prev = m_word; m_word = int'(din); m_valid = 1;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic r, e;
    logic [15:0] din;
    rst = 1'b1; en_ir = 1'b0; d_in = 16'h0000;
    @(negedge clk);

    step("reset", 1'b1, 1'b0, 16'h0000);
    step("reset2", 1'b1, 1'b1, 16'hFFFF);

    // Load from idle
    step("load_idle", 1'b0, 1'b1, 16'h00B1);
    check("tp.imm_b1", imm_sext, 16'hFFB1);
    check("tp.rs_b1", {12'b0, rs}, 16'h000B);

    // Reset priority over enable, held for three cycles
    step("rst_prio0", 1'b1, 1'b1, 16'h1131);
    step("rst_prio1", 1'b1, 1'b1, 16'h1131);
    step("rst_prio2", 1'b1, 1'b1, 16'h2222);
    check("tp.rst_hold", d_out, 16'h0000);

    // Reset releasing with en_ir high: first load lands one edge later
    step("rst_rel", 1'b0, 1'b1, 16'h00B1);

    // Hold with changing d_in
    step("hold0", 1'b0, 1'b0, 16'h80B1);
    step("hold1", 1'b0, 1'b0, 16'hCCB1);
    check("tp.hold", d_out, 16'h00B1);

    // Re-enable and class boundaries
    step("cls_mem", 1'b0, 1'b1, 16'h80B1);
    check("tp.cls_mem", {14'b0, cls}, 16'd1);
    step("cls_br", 1'b0, 1'b1, 16'hCCB1);
    check("tp.cls_br", {14'b0, cls}, 16'd2);
    check("tp.rd_c", {12'b0, rd}, 16'h000C);
    step("cls_sys", 1'b0, 1'b1, 16'hF000);
    check("tp.cls_sys", {14'b0, cls}, 16'd3);
    step("op7", 1'b0, 1'b1, 16'h7FFF);
    step("opB", 1'b0, 1'b1, 16'hB07F);
    step("opD", 1'b0, 1'b1, 16'hD080);
    step("opE", 1'b0, 1'b1, 16'hE000);

    // Back-to-back loads
    step("b2b0", 1'b0, 1'b1, 16'h11F1);
    check("tp.imm_f1", imm_sext, 16'hFFF1);
    step("b2b1", 1'b0, 1'b1, 16'h1131);
    check("tp.imm_31", imm_sext, 16'h0031);
    step("ones", 1'b0, 1'b1, 16'hFFFF);

`ifdef IR_SHADOW_EN
    step("sh_load0", 1'b0, 1'b1, 16'h00B1);
    step("sh_load1", 1'b0, 1'b1, 16'h1131);
    check("tp.prev", prev_ir, 16'h00B1);
    step("sh_hold", 1'b0, 1'b0, 16'h5555);
    step("sh_rst", 1'b1, 1'b0, 16'h5555);
    check("tp.prev_rst", prev_ir, 16'h0000);
`endif

    // Randomized traffic with occasional resets and all-ones words
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 19) == 0);
      e   = ($urandom_range(0, 1) == 1);
      din = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      step("rand", r, e, din);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_reg.md
# instr_reg

16-bit instruction register (module `instr_reg`) for the single-cycle processor datapath. It captures the fetched instruction word on a load enable, holds it stable for the rest of the instruction, and presents both the raw word and pre-decoded instruction fields to the control unit and register file. It sits between the instruction memory read port and the decode/control logic.

## Interface
Parameters:
- `W`, 16: instruction word width; fixed at 16 for this processor; field positions assume 16.

Ports:
- `clk`  in  1: single clock, rising-edge active.
- `rst`  in  1: synchronous, active-high reset.
- `d_in`  in  16: instruction word from instruction memory.
- `en_ir`  in  1: load enable; capture `d_in` on the next rising edge.
- `d_out`  out  16: registered instruction word.
- `ir_valid`  out  1: high once a word has been loaded since the last reset.
- `opcode`  out  4: `d_out[15:12]`.
- `rd`  out  4: `d_out[11:8]`.
- `rs`  out  4: `d_out[7:4]`.
- `func`  out  4: `d_out[3:0]`.
- `imm_sext`  out  16: `d_out[7:0]` sign-extended to 16 bits.
- `cls`  out  2: instruction class: 0 ALU (opcode 0–7), 1 MEM (8–11), 2 BRANCH (12–13), 3 SYS (14–15).

## Operation
- Priority at each rising edge: `rst`, then `en_ir`, then hold.
  - `rst`=1: `d_out` ← 0 and `ir_valid` ← 0, regardless of `en_ir`.
  - `rst`=0, `en_ir`=1: `d_out` ← `d_in` and `ir_valid` ← 1.
  - `rst`=0, `en_ir`=0: all registers hold.
- Reset values:
  - `d_out`=0x0000 and `ir_valid`=0.
  - Decode outputs derive from 0x0000: `opcode`=`rd`=`rs`=`func`=0, `imm_sext`=0, `cls`=0.
- Decode outputs are purely combinational functions of the registered `d_out`, never of `d_in`.
- `d_in` content is opaque: any 16-bit value, including X-free all-ones, is loaded verbatim. There are no illegal opcodes at this level.
- Continuous `rst`=1 keeps the register at 0 indefinitely, even with `en_ir`=1 and changing `d_in`.

## Timing
- Load latency is 1 cycle: `d_in` sampled at edge N appears on `d_out` and all decode outputs after edge N, within the same cycle.
- Back-to-back loads with `en_ir` held high capture a new word every cycle.
- Reset deasserting with `en_ir`=1 at the same edge: that edge still resets, because reset wins. The first load occurs at the following edge.
- Reset asserted mid-hold clears at that edge. There is no partial or held state.
- No combinational path from `d_in` or `en_ir` to any output.

## Configuration
- `IR_SHADOW_EN` defined:
  - Adds output `prev_ir` [15:0], holding the word `d_out` contained before the most recent load.
  - On a load, `prev_ir` ← old `d_out`.
  - Reset clears `prev_ir` to 0.
  - `prev_ir` holds whenever `d_out` holds.
- `IR_SHADOW_EN` undefined: the `prev_ir` port and its register are absent, and behaviour is otherwise identical.

## Structure
- Package `instr_reg_pkg`:
  - Field position/width constants (`OPC_MSB`=15, `OPC_LSB`=12, `RD_LSB`=8, `RS_LSB`=4, `IMM_W`=8).
  - Class encoding enum `ir_cls_t` (`CLS_ALU`, `CLS_MEM`, `CLS_BRANCH`, `CLS_SYS`).
  - Opcode range boundaries.
- Sub-module `instr_reg_decode`: purely combinational, maps the 16-bit word to `opcode`/`rd`/`rs`/`func`/`imm_sext`/`cls`. The top holds the register, the valid flag and the optional shadow.

## Test plan
- Load from idle: reset, then `d_in`=0x00B1 with `en_ir`=1 → next edge `d_out`=0x00B1, `ir_valid`=1, `opcode`=0, `rs`=0xB, `func`=1, `imm_sext`=0xFFB1, `cls`=0.
- Reset priority: `rst`=1, `en_ir`=1, `d_in`=0x1131 held for 3 cycles → `d_out` stays 0x0000 and `ir_valid`=0 throughout.
- Hold: load 0x00B1, then `en_ir`=0 with `d_in`=0x80B1 then 0xCCB1 → `d_out` remains 0x00B1.
- Re-enable and class: `en_ir`=1 with `d_in`=0x80B1 → `cls`=1. Then 0xCCB1 → `cls`=2, `rd`=0xC. Then 0xF000 → `cls`=3.
- Back-to-back loads: 0x11F1 then 0x1131 on consecutive edges → `d_out` follows with 1-cycle latency. For 0x11F1, `imm_sext`=0xFFF1; for 0x1131, `imm_sext`=0x0031.
- With `IR_SHADOW_EN`: load 0x00B1 then 0x1131 → `prev_ir`=0x00B1. Reset → `prev_ir`=0x0000.
